// File: rtl/if_id_queue.sv
// Fetch queue plus IF/ID register: buffers fetched (pc, inst) pairs
// and presents one registered instruction per cycle to decode.
module if_id_queue #(
   parameter int  DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       stall,
   input  logic             flush,
   input  logic             fetch_valid,
   input  logic [31:0]      fetch_pc,
   input  logic [31:0]      fetch_inst,
   output logic             fetch_ready,
   output logic             id_valid,
   output logic [31:0]      id_pc,
   output logic [31:0]      id_inst,
   output logic [PTR_W:0]   count
);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   localparam logic [PTR_W:0]   FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0] ONE  = PTR_W'(1);

   entry_t           mem [DEPTH];
   entry_t           head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;
   logic             stop_if;
   logic             stop_id;
   logic             unused;

   assign stop_if = stall[1];
   assign stop_id = stall[2];
   assign unused  = ^{stall[5:3], stall[0]};

   // Ready looks only at occupancy, never at a same-cycle pop.
   assign fetch_ready = (count != FULL);
   assign push = fetch_valid && fetch_ready && !flush;
   assign pop  = !flush && !stop_id && !stop_if && (count != '0);
   assign head = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{pc: fetch_pc, inst: fetch_inst};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + ONE;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Flush outranks an ID stop; an IF-only stop drains into a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_valid <= 1'b0;
         id_pc    <= '0;
         id_inst  <= '0;
      end else begin
         priority case (1'b1)
            flush: begin
               id_valid <= 1'b0;
               id_pc    <= '0;
               id_inst  <= '0;
            end
            stop_id: begin
               id_valid <= id_valid;
               id_pc    <= id_pc;
               id_inst  <= id_inst;
            end
            stop_if: begin
               id_valid <= 1'b0;
               id_pc    <= '0;
               id_inst  <= '0;
            end
            (count != '0): begin
               id_valid <= 1'b1;
               id_pc    <= head.pc;
               id_inst  <= head.inst;
            end
            default: begin
               id_valid <= 1'b0;
               id_pc    <= '0;
               id_inst  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: driver queues expected instructions,
// monitor pops and compares each new ID presentation.
module tb_if_id_queue;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  stall = '0;
   logic        flush = 1'b0;
   logic        fv = 1'b0;
   logic [31:0] fpc = '0;
   logic [31:0] finst = '0;
   logic        fetch_ready;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic [2:0]  count;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   bit   held = 1'b0;

   if_id_queue #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .fetch_valid(fv), .fetch_pc(fpc), .fetch_inst(finst),
      .fetch_ready(fetch_ready), .id_valid(id_valid),
      .id_pc(id_pc), .id_inst(id_inst), .count(count)
   );

   always #5 clk = ~clk;

   // An ID stop at an edge re-shows the same instruction; skip it.
   always @(posedge clk) begin
      held = !rst && stall[2] && !flush;
   end

   always @(negedge clk) begin
      if (!rst && id_valid && !held) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL order: got pc %h inst %h, required none",
                     id_pc, id_inst);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (id_pc !== e.pc || id_inst !== e.inst) begin
               errors++;
               $display("FAIL order: got pc %h inst %h, required pc %h inst %h",
                        id_pc, id_inst, e.pc, e.inst);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic drive(bit v, logic [31:0] p, logic [31:0] i, bit acc);
      fv    = v;
      fpc   = p;
      finst = i;
      if (acc) begin
         sb.push_back('{pc: p, inst: i});
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(id_valid), 0);
      chk("rst_pc", id_pc, 0);
      chk("rst_inst", id_inst, 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_ready", 32'(fetch_ready), 1);
      rst = 1'b0;

      // streaming
      for (int k = 0; k < 8; k++) begin
         drive(1, 32'(4*k), 32'h34010001 + 32'(k), 1);
         tick();
         if (k == 0) begin
            chk("stream_first_bubble", 32'(id_valid), 0);
         end else begin
            chk("stream_valid", 32'(id_valid), 1);
            chk("stream_pc", id_pc, 32'(4*(k-1)));
         end
         chk("stream_count", 32'(count), 1);
      end
      drive(0, 0, 0, 0);
      tick();
      chk("stream_last_pc", id_pc, 32'h1c);
      chk("stream_last_count", 32'(count), 0);
      tick();
      chk("stream_end_valid", 32'(id_valid), 0);
      chk("stream_end_inst", id_inst, 0);

      // fill under ID stop, then drain and wrap
      stall = 6'b000100;
      for (int k = 0; k < 6; k++) begin
         drive(1, 32'(4*k), 32'h20 + 32'(k), k < 4);
         tick();
         chk("fill_count", 32'(count), (k < 4) ? 32'(k+1) : 4);
         chk("fill_ready", 32'(fetch_ready), (k < 3) ? 1 : 0);
         chk("fill_hold", 32'(id_valid), 0);
      end
      stall = '0;
      drive(0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("drain_pc", id_pc, 32'(4*k));
         chk("drain_count", 32'(count), 32'(3-k));
      end
      for (int k = 0; k < 4; k++) begin
         drive(1, 32'h10 + 32'(4*k), 32'h24 + 32'(k), 1);
         tick();
      end
      drive(0, 0, 0, 0);
      tick();
      chk("wrap_last_pc", id_pc, 32'h1c);
      tick();
      chk("wrap_count", 32'(count), 0);
      chk("wrap_bubble", 32'(id_valid), 0);

      // IF-only stall
      stall = 6'b000100;
      drive(1, 32'h200, 32'h8c010000, 1);
      tick();
      drive(1, 32'h204, 32'h8c010004, 1);
      tick();
      chk("ifst_count0", 32'(count), 2);
      drive(0, 0, 0, 0);
      stall = 6'b000010;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("ifst_valid", 32'(id_valid), 0);
         chk("ifst_inst", id_inst, 0);
         chk("ifst_count", 32'(count), 2);
      end
      stall = '0;
      tick();
      chk("ifst_resume_pc", id_pc, 32'h200);
      chk("ifst_resume_count", 32'(count), 1);
      tick();
      chk("ifst_next_pc", id_pc, 32'h204);
      tick();
      chk("ifst_end_valid", 32'(id_valid), 0);

      // flush together with ID stop
      drive(1, 32'h300, 32'h1, 1);
      tick();
      drive(1, 32'h304, 32'h2, 1);
      tick();
      stall = 6'b000100;
      drive(1, 32'h308, 32'h3, 1);
      tick();
      drive(1, 32'h30c, 32'h4, 1);
      tick();
      chk("pre_flush_count", 32'(count), 3);
      chk("pre_flush_valid", 32'(id_valid), 1);
      chk("pre_flush_pc", id_pc, 32'h300);
      flush = 1'b1;
      drive(1, 32'h40, 32'hdead, 0);
      tick();
      sb.delete();
      chk("flush_valid", 32'(id_valid), 0);
      chk("flush_pc", id_pc, 0);
      chk("flush_count", 32'(count), 0);
      flush = 1'b0;
      stall = '0;
      drive(1, 32'h100, 32'h34020002, 1);
      tick();
      chk("post_flush_bubble", 32'(id_valid), 0);
      chk("post_flush_count", 32'(count), 1);
      drive(0, 0, 0, 0);
      tick();
      chk("post_flush_valid", 32'(id_valid), 1);
      chk("post_flush_pc", id_pc, 32'h100);
      tick();

      // full with simultaneous pop
      stall = 6'b000100;
      for (int k = 0; k < 4; k++) begin
         drive(1, 32'h500 + 32'(4*k), 32'h50 + 32'(k), 1);
         tick();
      end
      chk("full_count", 32'(count), 4);
      chk("full_ready", 32'(fetch_ready), 0);
      stall = '0;
      drive(1, 32'h510, 32'h60, 0);
      #1;
      chk("full_pop_ready", 32'(fetch_ready), 0);
      tick();
      chk("full_pop_count", 32'(count), 3);
      chk("full_reready", 32'(fetch_ready), 1);
      chk("full_pop_pc", id_pc, 32'h500);
      drive(1, 32'h514, 32'h61, 1);
      tick();
      chk("pushpop_count", 32'(count), 3);
      chk("pushpop_pc", id_pc, 32'h504);
      drive(0, 0, 0, 0);
      repeat (4) tick();
      chk("full_drain_count", 32'(count), 0);
      chk("full_drain_valid", 32'(id_valid), 0);

      // asynchronous reset mid-operation
      drive(1, 32'h600, 32'h70, 1);
      tick();
      drive(1, 32'h604, 32'h71, 1);
      tick();
      stall = 6'b000100;
      drive(1, 32'h608, 32'h72, 1);
      tick();
      drive(1, 32'h60c, 32'h73, 1);
      tick();
      chk("mid_count", 32'(count), 3);
      chk("mid_valid", 32'(id_valid), 1);
      drive(0, 0, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      sb.delete();
      chk("arst_valid", 32'(id_valid), 0);
      chk("arst_pc", id_pc, 0);
      chk("arst_inst", id_inst, 0);
      chk("arst_count", 32'(count), 0);
      chk("arst_ready", 32'(fetch_ready), 1);
      tick();
      rst = 1'b0;
      stall = '0;
      tick();
      chk("after_rst_valid", 32'(id_valid), 0);
      chk("sb_empty", 32'(sb.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction fetch queue and IF/ID pipeline register for the OpenMIPS core. It sits between the fetch stage (pc_reg plus instruction ROM) and the decode stage. It buffers up to DEPTH fetched (pc, instruction) pairs so fetch and decode are decoupled, and presents one registered instruction per cycle to ID. It honours the CTRL stall vector and a branch flush.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, 2..16
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- stall  input  6  CTRL stall vector; bit1 = IF stalled, bit2 = ID stalled (1 = Stop)
- flush  input  1  branch/exception redirect; discard all buffered and presented instructions
- fetch_valid  input  1  fetch_pc/fetch_inst valid this cycle (fetch ce-qualified)
- fetch_pc  input  32  address of fetched instruction
- fetch_inst  input  32  fetched instruction word
- fetch_ready  output  1  queue can accept; fetch holds pc when low
- id_valid  output  1  id_pc/id_inst hold a real instruction
- id_pc  output  32  instruction address to ID
- id_inst  output  32  instruction word to ID (0 = nop bubble)
- count  output  PTR_W+1  current queue occupancy, 0..DEPTH

## Operation
- Storage: circular buffer of DEPTH entries {pc, inst}. It uses a write pointer, a read pointer, and an occupancy counter. Pointers wrap modulo DEPTH.
- fetch_ready = (count != DEPTH). It is combinational from the counter only and does not look ahead to a same-cycle pop.
- Push occurs when fetch_valid && fetch_ready && !flush. It writes the entry at wr_ptr and increments wr_ptr.
- The output stage (id_valid/id_pc/id_inst registers) updates each edge by priority:
  1. flush: outputs become the bubble (valid 0, pc 0, inst 0). Queue is emptied (pointers 0, count 0). No push occurs.
  2. stall[2]=Stop: outputs hold. No pop.
  3. stall[1]=Stop, stall[2]=NoStop: outputs become the bubble. No pop.
  4. stall[2]=NoStop, count>0: load the head entry with valid=1. rd_ptr increments (pop).
  5. stall[2]=NoStop, count=0: outputs become the bubble.
- Counter update: count_next = count + push − pop, in the range 0..DEPTH. Simultaneous push and pop leaves count unchanged.
- No bypass path exists. A pushed entry becomes poppable on the following cycle.
- Reset (asynchronous, any time, including mid-stall or when full):
  - id_valid=0, id_pc=0, id_inst=0.
  - count=0, pointers=0.
  - fetch_ready=1 while count=0.
- Queue storage contents are not reset. They are never observable without a prior push.

## Timing
- Minimum latency is 2 rising edges from a fetch beat to the ID output. The push lands at edge N and the pop into the output register happens at edge N+1.
- Steady state, with no stalls and a non-empty queue, is 1 instruction per cycle with no bubbles.
- Full boundary: at count=DEPTH, fetch_ready=0 even if a pop occurs that cycle. fetch_ready reasserts the cycle after the pop.
- Empty boundary: at count=0 with stall[2]=NoStop, a bubble is inserted.
- flush takes effect at the next edge. id_valid=0 and count=0 after that edge. A fetch beat presented in the flush cycle is dropped.
- A flush coinciding with stall[2]=Stop still clears: flush has priority.
- Instruction order is strictly preserved across pointer wrap.

## Test plan
- Reset mid-operation: with count=3 and id_valid=1, pulse rst asynchronously. Expect id_valid=0, id_pc=0, id_inst=0, count=0 immediately, and fetch_ready=1.
- Streaming: push pc 0x0,0x4,0x8,... with insts 0x34010001+k and no stalls. Expect the first id_valid at the 2nd edge after the first push, then one instruction per cycle in order, with count steady at 1.
- Fill and wrap: hold stall=6'b000100 while pushing 6 beats, DEPTH=4. Expect fetch_ready=0 after 4 pushes and count=4. Release stall and verify pc 0x0..0xC emerge in order. Push 4 more and verify correct order across the wrap.
- IF-only stall: with count=2, set stall=6'b000010 for 2 cycles. Expect 2 bubbles (id_valid=0, id_inst=0), count unchanged at 2, then resumption with the correct next pc.
- Flush: with count=3 and id_valid=1, assert flush for one cycle while fetch_valid=1 with pc 0x40. Expect id_valid=0 and count=0 after the edge, and pc 0x40 never emitted. The next fetch of pc 0x100 appears 2 edges later.
- Simultaneous push/pop when full: at count=DEPTH with stall[2]=NoStop and fetch_valid=1, expect fetch_ready=0, the beat not accepted, and count=DEPTH−1. The next cycle gives fetch_ready=1 and the push accepted.
